loop_gain_scheduler: RTL and testbench
======================================

# loop_gain_scheduler

Gear-shift controller for the PI timing-loop filter. It sits between the Gardner TED and the PI loop filter. It forwards the timing error, measures error magnitude over fixed symbol windows, and runs an acquire/track state machine. That state machine selects the filter's proportional and integral shift gains and clears the filter integrator when re-acquisition starts.

## Interface
Parameters:
- WERR, 18: width of timing error in/out.
- WIN_LOG2, 6: window length = 2^WIN_LOG2 error strobes.
- SHW, 5: width of gain-shift outputs.
- KP_ACQ, 5 / KI_ACQ, 9: acquisition shifts (wide loop).
- KP_TRK, 7 / KI_TRK, 12: tracking shifts (narrow loop).
- LOCK_THR, 2048: window mean |e| strictly below this counts as a "good" window.
- UNLOCK_THR, 8192: window mean |e| strictly above this counts as a "bad" window.
- LOCK_CNT, 4: consecutive good windows needed to lock.
- UNLOCK_CNT, 2: consecutive bad windows needed to drop lock.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high reset.
- enable_i, in, 1: loop enable, level.
- force_acq_i, in, 1: 1-cycle request to restart acquisition.
- e_in_i, in, WERR signed: timing error from the TED.
- e_valid_i, in, 1: 1-cycle strobe marking a valid e_in_i.
- e_o, out, WERR signed: registered copy of e_in_i, to the filter.
- e_valid_o, out, 1: registered e_valid_i; forced low in IDLE.
- kp_shift_o, out, SHW: proportional shift to the filter.
- ki_shift_o, out, SHW: integral shift to the filter.
- filt_clr_o, out, 1: 1-cycle integrator clear to the filter.
- locked_o, out, 1: high while in TRACK.
- state_o, out, 2: IDLE=0, ACQ=1, TRACK=2.
- win_mean_o, out, WERR-1: mean |e| of the last completed window (debug).

## Operation
- |e| is computed as e when e ≥ 0, else −e. The most negative input saturates to 2^(WERR-1)-1.
- Window accumulator: unsigned, WERR-1+WIN_LOG2 bits, cannot overflow. A strobe counter runs 0..2^WIN_LOG2-1.
  - On the final strobe of a window, mean = (sum + |e|) >> WIN_LOG2 (truncating).
  - The mean is compared against both thresholds.
  - The accumulator and counter restart with the next strobe.
- Lock and unlock counters each saturate at their target value. A window that is neither good nor bad clears both counters.
- State transitions:
  - IDLE: gains = ACQ values, no counting. Goes to ACQ when enable_i=1; this entry pulses filt_clr_o.
  - ACQ: a good window increments the good count and clears the bad count. When the good count reaches LOCK_CNT, go to TRACK and clear both counters.
  - TRACK: a bad window increments the bad count and clears the good count. When the bad count reaches UNLOCK_CNT, go to ACQ, pulse filt_clr_o, and clear the counters.
  - Any state, enable_i=0: go to IDLE and clear the window and counters. This takes priority over everything else.
  - ACQ or TRACK, force_acq_i=1: go to ACQ, pulse filt_clr_o, clear the window and counters. This overrides a same-cycle window decision.
- Gain outputs are registered from the next state: KP_ACQ/KI_ACQ in IDLE and ACQ, KP_TRK/KI_TRK in TRACK.

## Timing
- Reset values:
  - state IDLE;
  - e_o=0, e_valid_o=0, filt_clr_o=0, locked_o=0;
  - kp_shift_o=KP_ACQ, ki_shift_o=KI_ACQ;
  - win_mean_o=0;
  - all counters and the accumulator 0.
- e_o and e_valid_o have 1-cycle latency.
- Window decision: on the clock edge that samples the final strobe, the state, gains, locked_o and win_mean_o update together. They are visible in the same cycle as the e_valid_o of that strobe.
  - The filter therefore applies new gains from the next strobe onward.
- filt_clr_o is asserted the cycle after the triggering enable edge, force, or unlock decision, for exactly 1 cycle.
  - In that cycle e_valid_o is forced to 0 so the cleared integrator does not absorb a stale error.
- A strobe arriving with force_acq_i in the same cycle is discarded from the new window.
- Async reset mid-window returns every output to its reset value immediately. Operation resumes on the first edge after reset deasserts.

## Structure
- Shared package loop_ctrl_pkg holds:
  - typedef enum logic [1:0] loop_state_t {IDLE, ACQ, TRACK};
  - the SHW default;
  - default gain and threshold constants, so the loop filter and this block share one source.
- Sub-module err_window_avg: the abs/saturation, accumulator and strobe counter. Its outputs are a mean and a 1-cycle win_done pulse; it takes a clear input. The FSM stays in the top module.

## Test plan
- Reset/enable: hold enable_i=0 with strobes present -> state_o=0, e_valid_o=0, gains 5/9. Raise enable_i -> next cycle filt_clr_o=1 for one cycle, state_o=1.
- Acquire: 4 windows of 64 strobes with e=±1000 -> after the 256th strobe locked_o=1, gains 7/12, win_mean_o=1000.
- Hysteresis: in TRACK, feed alternating windows at |e|=9000 and |e|=4000 -> stays locked. Then 2 consecutive windows at 9000 -> ACQ, filt_clr_o pulse, gains 5/9.
- Saturation: 64 strobes of e=−131072 -> win_mean_o=131071, no overflow.
- Force: force_acq_i coincident with the final strobe of a 4th good window -> state ACQ (not TRACK), counters cleared, filt_clr_o pulse, e_valid_o low in the clear cycle.
- Reset mid-window: assert reset after 30 strobes -> all outputs at reset values asynchronously. The first window after release needs a full 64 strobes.

Source files
------------

// File: rtl/loop_ctrl_pkg.sv
// Shared types and default constants for the timing-loop gear-shift controller
// and the PI loop filter, so both blocks take their gains from one place.
package loop_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } loop_state_t;

  localparam int unsigned DEF_WERR       = 18;
  localparam int unsigned DEF_WIN_LOG2   = 6;
  localparam int unsigned DEF_SHW        = 5;
  localparam int unsigned DEF_KP_ACQ     = 5;
  localparam int unsigned DEF_KI_ACQ     = 9;
  localparam int unsigned DEF_KP_TRK     = 7;
  localparam int unsigned DEF_KI_TRK     = 12;
  localparam int unsigned DEF_LOCK_THR   = 2048;
  localparam int unsigned DEF_UNLOCK_THR = 8192;
  localparam int unsigned DEF_LOCK_CNT   = 4;
  localparam int unsigned DEF_UNLOCK_CNT = 2;

  function automatic logic is_running(loop_state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/err_window_avg.sv
// Mean |e| over fixed windows of 2^WIN_LOG2 strobes. mean_o/win_done_o are
// combinational on the final strobe so the caller can register the decision.
module err_window_avg
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned WERR     = DEF_WERR,
  parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic signed [WERR-1:0] e_i,
  input  logic                   e_valid_i,
  output logic        [WERR-2:0] mean_o,
  output logic                   win_done_o
);

  localparam int unsigned AW = WERR - 1 + WIN_LOG2;

  logic [AW-1:0]       acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [WERR-1:0]     neg_e;
  logic [WERR-2:0]     abs_e;
  logic [AW-1:0]       sum;
  logic                last;

  always_comb begin
    neg_e = -e_i;
    // Negating the most negative code wraps back to itself; clamp it instead.
    if (!e_i[WERR-1]) begin
      abs_e = e_i[WERR-2:0];
    end else if (neg_e[WERR-1]) begin
      abs_e = '1;
    end else begin
      abs_e = neg_e[WERR-2:0];
    end
    sum        = acc_q + AW'(abs_e);
    last       = &cnt_q;
    win_done_o = e_valid_i & last & ~clr_i;
    mean_o     = sum[AW-1:WIN_LOG2];
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (e_valid_i) begin
      cnt_d = cnt_q + WIN_LOG2'(1);
      acc_d = last ? '0 : sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/loop_gain_scheduler.sv
// Acquire/track gear-shift controller between the Gardner TED and PI filter:
// forwards the error, grades error windows and schedules filter gains.
module loop_gain_scheduler
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned WERR       = DEF_WERR,
  parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2,
  parameter int unsigned SHW        = DEF_SHW,
  parameter int unsigned KP_ACQ     = DEF_KP_ACQ,
  parameter int unsigned KI_ACQ     = DEF_KI_ACQ,
  parameter int unsigned KP_TRK     = DEF_KP_TRK,
  parameter int unsigned KI_TRK     = DEF_KI_TRK,
  parameter int unsigned LOCK_THR   = DEF_LOCK_THR,
  parameter int unsigned UNLOCK_THR = DEF_UNLOCK_THR,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
  parameter int unsigned UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic                   force_acq_i,
  input  logic signed [WERR-1:0] e_in_i,
  input  logic                   e_valid_i,
  output logic signed [WERR-1:0] e_o,
  output logic                   e_valid_o,
  output logic        [SHW-1:0]  kp_shift_o,
  output logic        [SHW-1:0]  ki_shift_o,
  output logic                   filt_clr_o,
  output logic                   locked_o,
  output logic        [1:0]      state_o,
  output logic        [WERR-2:0] win_mean_o
);

  localparam int unsigned CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [WERR-1:0] LOCK_THR_V   = WERR'(LOCK_THR);
  localparam logic [WERR-1:0] UNLOCK_THR_V = WERR'(UNLOCK_THR);

  loop_state_t state_q, state_d;
  logic [CW-1:0] good_q, good_d, bad_q, bad_d;
  logic [CW-1:0] good_inc, bad_inc;
  logic          clr_d, filt_clr_q;
  logic          ev_d, ev_q;
  logic signed [WERR-1:0] e_q;
  logic [SHW-1:0]  kp_d, kp_q, ki_d, ki_q;
  logic [WERR-2:0] mean_d, mean_q;
  logic            win_clr, win_done, is_good, is_bad;
  logic [WERR-2:0] win_mean;

  // The window restarts whenever the loop is held off or acquisition is restarted.
  assign win_clr = ~enable_i | (state_q == IDLE) | force_acq_i;

  err_window_avg #(
    .WERR     (WERR),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (win_clr),
    .e_i        (e_in_i),
    .e_valid_i  (e_valid_i),
    .mean_o     (win_mean),
    .win_done_o (win_done)
  );

  assign is_good  = {1'b0, win_mean} < LOCK_THR_V;
  assign is_bad   = {1'b0, win_mean} > UNLOCK_THR_V;
  assign good_inc = (good_q == CW'(LOCK_CNT))   ? good_q : good_q + CW'(1);
  assign bad_inc  = (bad_q  == CW'(UNLOCK_CNT)) ? bad_q  : bad_q  + CW'(1);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    clr_d   = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          clr_d   = 1'b1;
          good_d  = '0;
          bad_d   = '0;
        end
        ACQ, TRACK: begin
          if (force_acq_i) begin
            state_d = ACQ;
            clr_d   = 1'b1;
            good_d  = '0;
            bad_d   = '0;
          end else if (win_done) begin
            // Any window that is neither good nor bad breaks both streaks.
            if (is_good) begin
              good_d = good_inc;
              bad_d  = '0;
            end else if (is_bad) begin
              bad_d  = bad_inc;
              good_d = '0;
            end else begin
              good_d = '0;
              bad_d  = '0;
            end
            if (state_q == ACQ && good_d == CW'(LOCK_CNT)) begin
              state_d = TRACK;
              good_d  = '0;
              bad_d   = '0;
            end else if (state_q == TRACK && bad_d == CW'(UNLOCK_CNT)) begin
              state_d = ACQ;
              clr_d   = 1'b1;
              good_d  = '0;
              bad_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
          bad_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    kp_d   = (state_d == TRACK) ? SHW'(KP_TRK) : SHW'(KP_ACQ);
    ki_d   = (state_d == TRACK) ? SHW'(KI_TRK) : SHW'(KI_ACQ);
    // Hold back the strobe that coincides with an integrator clear.
    ev_d   = e_valid_i & is_running(state_d) & ~clr_d;
    mean_d = win_done ? win_mean : mean_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      good_q     <= '0;
      bad_q      <= '0;
      filt_clr_q <= 1'b0;
      ev_q       <= 1'b0;
      e_q        <= '0;
      kp_q       <= SHW'(KP_ACQ);
      ki_q       <= SHW'(KI_ACQ);
      mean_q     <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      filt_clr_q <= clr_d;
      ev_q       <= ev_d;
      e_q        <= e_in_i;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      mean_q     <= mean_d;
    end
  end

  assign e_o        = e_q;
  assign e_valid_o  = ev_q;
  assign kp_shift_o = kp_q;
  assign ki_shift_o = ki_q;
  assign filt_clr_o = filt_clr_q;
  assign locked_o   = (state_q == TRACK);
  assign state_o    = state_q;
  assign win_mean_o = mean_q;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Randomised scoreboard bench for loop_gain_scheduler against a windowed-mean
// reference model of the acquire/track rules.
module tb_loop_gain_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable_i;
  logic               force_acq_i;
  logic signed [17:0] e_in_i;
  logic               e_valid_i;
  logic signed [17:0] e_o;
  logic               e_valid_o;
  logic [4:0]         kp_shift_o;
  logic [4:0]         ki_shift_o;
  logic               filt_clr_o;
  logic               locked_o;
  logic [1:0]         state_o;
  logic [16:0]        win_mean_o;

  loop_gain_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (enable_i),
    .force_acq_i (force_acq_i),
    .e_in_i      (e_in_i),
    .e_valid_i   (e_valid_i),
    .e_o         (e_o),
    .e_valid_o   (e_valid_o),
    .kp_shift_o  (kp_shift_o),
    .ki_shift_o  (ki_shift_o),
    .filt_clr_o  (filt_clr_o),
    .locked_o    (locked_o),
    .state_o     (state_o),
    .win_mean_o  (win_mean_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    int state;
    int locked;
    int kp;
    int ki;
    int mean;
  } exp_t;

  exp_t exp_q[$];
  int   clr_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: window of |e| samples, streak counts and loop state.
  int m_state, m_good, m_bad, m_sum, m_cnt, m_mean;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic int abs_sat(int e);
    if (e == -131072) return 131071;
    return (e < 0) ? -e : e;
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_sum = 0; m_cnt = 0; m_mean = 0;
  endtask

  task automatic model_step(input bit en, input bit frc, input bit v, input int e);
    bit   clr_now;
    bit   out_v;
    exp_t r;
    clr_now = 1'b0;
    out_v   = 1'b0;
    if (!en) begin
      m_state = 0; m_good = 0; m_bad = 0; m_sum = 0; m_cnt = 0;
    end else if (m_state == 0 || frc) begin
      m_state = 1; clr_now = 1'b1;
      m_good = 0; m_bad = 0; m_sum = 0; m_cnt = 0;
    end else begin
      if (v) begin
        m_sum += abs_sat(e);
        m_cnt++;
        if (m_cnt == 64) begin
          m_mean = m_sum / 64;
          m_sum = 0; m_cnt = 0;
          if (m_mean < 2048) begin
            m_good = (m_good < 4) ? m_good + 1 : 4; m_bad = 0;
          end else if (m_mean > 8192) begin
            m_bad = (m_bad < 2) ? m_bad + 1 : 2; m_good = 0;
          end else begin
            m_good = 0; m_bad = 0;
          end
          if (m_state == 1 && m_good == 4) begin
            m_state = 2; m_good = 0; m_bad = 0;
          end else if (m_state == 2 && m_bad == 2) begin
            m_state = 1; m_good = 0; m_bad = 0; clr_now = 1'b1;
          end
        end
      end
      out_v = v && !clr_now;
    end
    if (out_v) begin
      r.e = e; r.state = m_state; r.locked = (m_state == 2) ? 1 : 0;
      r.kp = (m_state == 2) ? 7 : 5;
      r.ki = (m_state == 2) ? 12 : 9;
      r.mean = m_mean;
      exp_q.push_back(r);
    end
    if (clr_now) clr_q.push_back(1);
  endtask

  task automatic step(input bit en, input bit frc, input bit v, input int e);
    enable_i    = en;
    force_acq_i = frc;
    e_valid_i   = v;
    e_in_i      = 18'(e);
    @(posedge clk);
    #1;
    model_step(en, frc, v, e);
    force_acq_i = 1'b0;
    e_valid_i   = 1'b0;
  endtask

  // n strobes with random gaps and |e| drawn from [lo,hi]; 131072 means -2^17.
  task automatic win(input int lo, input int hi, input int n, input bit force_last);
    int m;
    int e;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'b0, 0);
      m = int'($urandom_range(hi, lo));
      if (m >= 131072) e = -131072;
      else e = ($urandom % 2 != 0) ? -m : m;
      step(1'b1, force_last && (i == n - 1), 1'b1, e);
    end
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_e_o"}, int'(e_o), 0);
    chk({tag, "_e_valid"}, int'(e_valid_o), 0);
    chk({tag, "_filt_clr"}, int'(filt_clr_o), 0);
    chk({tag, "_locked"}, int'(locked_o), 0);
    chk({tag, "_kp"}, int'(kp_shift_o), 5);
    chk({tag, "_ki"}, int'(ki_shift_o), 9);
    chk({tag, "_mean"}, int'(win_mean_o), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or a clear.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (e_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_e_valid", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("sb_e_o", int'($signed(e_o)), r.e);
          chk("sb_state", int'(state_o), r.state);
          chk("sb_locked", int'(locked_o), r.locked);
          chk("sb_kp", int'(kp_shift_o), r.kp);
          chk("sb_ki", int'(ki_shift_o), r.ki);
          chk("sb_mean", int'(win_mean_o), r.mean);
        end
      end
      if (filt_clr_o) begin
        if (clr_q.size() == 0) begin
          chk("unexpected_filt_clr", 1, 0);
        end else begin
          void'(clr_q.pop_front());
          chk("clr_state", int'(state_o), 1);
          chk("clr_e_valid", int'(e_valid_o), 0);
          chk("clr_kp", int'(kp_shift_o), 5);
          chk("clr_ki", int'(ki_shift_o), 9);
        end
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1; enable_i = 1'b0; force_acq_i = 1'b0; e_valid_i = 1'b0; e_in_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    #3 reset = 1'b0;

    // Held disabled with strobes present.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, int'($urandom_range(5000, 0)));
    chk("idle_state", int'(state_o), 0);
    chk("idle_e_valid", int'(e_valid_o), 0);
    chk("idle_kp", int'(kp_shift_o), 5);
    chk("idle_ki", int'(ki_shift_o), 9);

    // Enable edge: one-cycle clear, enter ACQ.
    step(1'b1, 1'b0, 1'b0, 0);
    chk("enable_filt_clr", int'(filt_clr_o), 1);
    chk("enable_state", int'(state_o), 1);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("enable_clr_one_cycle", int'(filt_clr_o), 0);

    // Acquire with |e| = 1000.
    repeat (4) win(1000, 1000, 64, 1'b0);
    chk("acq_locked", int'(locked_o), 1);
    chk("acq_kp", int'(kp_shift_o), 7);
    chk("acq_ki", int'(ki_shift_o), 12);
    chk("acq_mean", int'(win_mean_o), 1000);

    // Hysteresis: alternating bad/neutral keeps lock, two bad drop it.
    repeat (2) begin
      win(8950, 9050, 64, 1'b0);
      win(3950, 4050, 64, 1'b0);
    end
    chk("hyst_locked", int'(locked_o), 1);
    win(8950, 9050, 64, 1'b0);
    win(8950, 9050, 64, 1'b0);
    chk("unlock_state", int'(state_o), 1);
    chk("unlock_filt_clr", int'(filt_clr_o), 1);
    chk("unlock_kp", int'(kp_shift_o), 5);

    // Saturation of the most negative error.
    win(131072, 131072, 64, 1'b0);
    chk("sat_mean", int'(win_mean_o), 131071);

    // Force on the final strobe of the 4th good window.
    repeat (3) win(0, 1500, 64, 1'b0);
    win(0, 1500, 64, 1'b1);
    chk("force_state", int'(state_o), 1);
    chk("force_filt_clr", int'(filt_clr_o), 1);
    chk("force_e_valid", int'(e_valid_o), 0);
    repeat (3) win(0, 1500, 64, 1'b0);
    chk("force_counts_cleared", int'(state_o), 1);
    win(0, 1500, 64, 1'b0);
    chk("relock_state", int'(state_o), 2);

    // Randomised mix of windows, forces and enable drops.
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(9, 0));
      case (r)
        0: step(1'b1, 1'b1, $urandom % 2 != 0, int'($urandom_range(3000, 0)));
        1: for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, int'($urandom_range(3000, 0)));
        2: win(0, 20000, int'($urandom_range(40, 1)), 1'b0);
        3, 4, 5: win(0, 2500, 64, 1'b0);
        6, 7: win(2500, 9500, 64, 1'b0);
        default: win(7000, 30000, 64, 1'b0);
      endcase
      chk("rand_state", int'(state_o), m_state);
      chk("rand_locked", int'(locked_o), (m_state == 2) ? 1 : 0);
    end

    // Asynchronous reset partway through a window.
    win(0, 1500, 30, 1'b0);
    #6;
    chk("pre_reset_queue", exp_q.size() + clr_q.size(), 0);
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    exp_q.delete();
    clr_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 0);
    win(500, 1500, 63, 1'b0);
    chk("post_reset_partial_mean", int'(win_mean_o), 0);
    win(500, 1500, 1, 1'b0);
    chk("post_reset_full_mean", int'(win_mean_o), m_mean);

    repeat (4) step(1'b1, 1'b0, 1'b0, 0);
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_clr_q", clr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
